// File: rtl/btn_pkg.sv
// btn_pkg: shared state encoding, default timing constants and counter width helper
package btn_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } btn_state_e;

    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int REPEAT_DELAY_DEF    = 64;
    localparam int REPEAT_PERIOD_DEF   = 16;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-flop synchroniser for a single asynchronous input bit
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // shift the asynchronous input through the flop chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= {sync_q[STAGES-2:0], d};
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/btn_debounce_pulser.sv
// btn_debounce_pulser: synchronise, debounce and turn button presses into single-cycle enable pulses
module btn_debounce_pulser
    import btn_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter bit REPEAT_EN       = 1'b1,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic pulse_o,
    output logic level_o,
    output logic busy_o
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_ph_q, rep_ph_d;
    logic             pulse_q, pulse_d;
    logic             level_q, level_d;
    logic             btn_s, db_done, rep_hit, acc, rel;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (btn_raw),
        .q    (btn_s)
    );

    // db_cnt already holds the samples seen so far, so this sample completes the run
    assign db_done = db_cnt_q >= DB_LAST;
    // rep_ph selects the initial delay or the steady repeat period
    assign rep_hit = rep_cnt_q >= (rep_ph_q ? PERIOD_LAST : DELAY_LAST);

    // next-state, counter and pulse decisions; accept/release override the per-state defaults
    always_comb begin
        state_d   = state_q;
        db_cnt_d  = db_cnt_q;
        rep_cnt_d = rep_cnt_q;
        rep_ph_d  = rep_ph_q;
        level_d   = level_q;
        pulse_d   = 1'b0;
        acc       = 1'b0;
        rel       = 1'b0;
        case (state_q)
            STABLE_LOW: begin
                if (btn_s) begin
                    acc      = db_done;
                    state_d  = WAIT_HIGH;
                    db_cnt_d = CNT_W'(1);
                end
            end
            WAIT_HIGH: begin
                if (!btn_s) begin
                    state_d  = STABLE_LOW;
                    db_cnt_d = '0;
                end else begin
                    acc      = db_done;
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            STABLE_HIGH: begin
                if (!btn_s) begin
                    rel      = db_done;
                    state_d  = WAIT_LOW;
                    db_cnt_d = CNT_W'(1);
                end else if (REPEAT_EN) begin
                    pulse_d   = rep_hit;
                    rep_cnt_d = rep_hit ? '0 : rep_cnt_q + 1'b1;
                    rep_ph_d  = rep_ph_q | rep_hit;
                end
            end
            WAIT_LOW: begin
                if (btn_s) begin
                    state_d  = STABLE_HIGH;
                    db_cnt_d = '0;
                end else begin
                    rel      = db_done;
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: state_d = STABLE_LOW;
        endcase
        if (acc) begin
            state_d   = STABLE_HIGH;
            db_cnt_d  = '0;
            rep_cnt_d = '0;
            rep_ph_d  = 1'b0;
            level_d   = 1'b1;
            pulse_d   = 1'b1;
        end
        if (rel) begin
            state_d   = STABLE_LOW;
            db_cnt_d  = '0;
            rep_cnt_d = '0;
            rep_ph_d  = 1'b0;
            level_d   = 1'b0;
        end
    end

    // state, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= STABLE_LOW;
            db_cnt_q  <= '0;
            rep_cnt_q <= '0;
            rep_ph_q  <= 1'b0;
            pulse_q   <= 1'b0;
            level_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            db_cnt_q  <= db_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            rep_ph_q  <= rep_ph_d;
            pulse_q   <= pulse_d;
            level_q   <= level_d;
        end
    end

    assign pulse_o = pulse_q;
    assign level_o = level_q;
    assign busy_o  = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);

endmodule

// File: tb/tb_btn_debounce_pulser.sv
// tb_btn_debounce_pulser: scoreboard bench driving a one-shot and an auto-repeat instance from one button
module tb_btn_debounce_pulser;

    typedef struct {
        int t;
        int who;
        int sig;
        int v;
    } exp_t;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       btn_raw = 1'b0;
    logic [1:0] pulse, level, busy;
    logic [3:0] cnt4 [2];
    int         cyc     = 0;
    int         checks  = 0;
    int         passed  = 0;
    bit         done    = 1'b0;
    int         pq [2][$];
    exp_t       eq [$];
    string      sig_name [3] = '{"level", "busy", "count"};

    // index 0: one pulse per press, index 1: auto-repeat
    btn_debounce_pulser #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b0), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) u_one (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
        .pulse_o(pulse[0]), .level_o(level[0]), .busy_o(busy[0])
    );

    btn_debounce_pulser #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b1), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
    ) u_rep (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
        .pulse_o(pulse[1]), .level_o(level[1]), .busy_o(busy[1])
    );

    // free-running clock
    always #5 clk = ~clk;

    // cycle index: number of rising edges so far
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: checks reset state, pops pulse and level/busy/count expectations, prints the summary
    always begin
        exp_t e;
        int   act;
        @(negedge clk or negedge rst_n);
        #1;
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                cnt4[i] = '0;
                checks++;
                if (pulse[i] == 1'b0) passed++;
                else $display("FAIL rst_pulse%0d: got %0b, want 0", i, pulse[i]);
                checks++;
                if (level[i] == 1'b0) passed++;
                else $display("FAIL rst_level%0d: got %0b, want 0", i, level[i]);
                checks++;
                if (busy[i] == 1'b0) passed++;
                else $display("FAIL rst_busy%0d: got %0b, want 0", i, busy[i]);
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                while (pq[i].size() > 0 && pq[i][0] < cyc) begin
                    checks++;
                    $display("FAIL pulse%0d: no pulse at cycle %0d (now %0d)", i, pq[i][0], cyc);
                    void'(pq[i].pop_front());
                end
                if (pulse[i]) begin
                    cnt4[i] = cnt4[i] + 1'b1;
                    checks++;
                    if (pq[i].size() > 0 && pq[i][0] == cyc) begin
                        passed++;
                        void'(pq[i].pop_front());
                    end else begin
                        $display("FAIL pulse%0d: pulse at cycle %0d, next expected %0d", i, cyc,
                                 pq[i].size() > 0 ? pq[i][0] : -1);
                    end
                end
            end
            while (eq.size() > 0 && eq[0].t <= cyc) begin
                e   = eq.pop_front();
                act = (e.sig == 0) ? int'(level[e.who]) : (e.sig == 1) ? int'(busy[e.who]) : int'(cnt4[e.who]);
                checks++;
                if (e.t == cyc && act == e.v) passed++;
                else $display("FAIL %s%0d @%0d: got %0d at cycle %0d, want %0d", sig_name[e.sig], e.who, e.t, act, cyc, e.v);
            end
            if (cyc > 2000) begin
                checks++;
                $display("FAIL timeout: cycle %0d, want < 2000", cyc);
            end
            if (done || cyc > 2000) begin
                for (int i = 0; i < 2; i++) begin
                    while (pq[i].size() > 0) begin
                        checks++;
                        $display("FAIL pulse%0d: expected pulse at cycle %0d never seen", i, pq[i][0]);
                        void'(pq[i].pop_front());
                    end
                end
                while (eq.size() > 0) begin
                    e = eq.pop_front();
                    checks++;
                    $display("FAIL %s%0d @%0d: never checked, want %0d", sig_name[e.sig], e.who, e.t, e.v);
                end
                $display("%0d/%0d checks passed", passed, checks);
                $finish;
            end
        end
    end

    task automatic at(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic ex(input int t, input int who, input int sig, input int v);
        eq.push_back('{t, who, sig, v});
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // stimulus: directed button waveforms with hand-computed pulse cycles and levels
    initial begin
        int         c, r, t;
        logic [7:0] pat;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // clean press: pulse 6 cycles after the first high sample, busy for cycles 3-5
        c = cyc;
        pq[0].push_back(c + 6);
        pq[1].push_back(c + 6);
        ex(c + 2, 0, 1, 0);  ex(c + 3, 0, 1, 1);  ex(c + 5, 0, 1, 1);  ex(c + 5, 0, 0, 0);
        ex(c + 6, 0, 1, 0);  ex(c + 6, 0, 0, 1);  ex(c + 6, 1, 0, 1);  ex(c + 8, 0, 1, 1);
        ex(c + 10, 0, 0, 1); ex(c + 11, 0, 0, 0); ex(c + 11, 1, 0, 0);
        btn_raw = 1'b1;
        at(c + 5);
        btn_raw = 1'b0;
        at(c + 14);

        // bounce: two bursts of three highs never qualify
        c   = cyc;
        pat = 8'b0111_0111;
        ex(c + 4, 0, 1, 1);  ex(c + 6, 0, 1, 0);  ex(c + 8, 0, 1, 1);
        ex(c + 12, 0, 0, 0); ex(c + 12, 0, 1, 0); ex(c + 12, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            btn_raw = pat[i];
            @(negedge clk);
        end
        btn_raw = 1'b0;
        at(c + 14);

        // auto-repeat: P, P+10, P+13, P+16, P+19; the P+22 repeat is cut off by the release
        do_reset();
        c = cyc;
        pq[0].push_back(c + 6);
        foreach (pq[1][i]) ;
        pq[1].push_back(c + 6);
        pq[1].push_back(c + 16);
        pq[1].push_back(c + 19);
        pq[1].push_back(c + 22);
        pq[1].push_back(c + 25);
        ex(c + 27, 0, 2, 1); ex(c + 27, 1, 2, 5); ex(c + 30, 1, 0, 1); ex(c + 31, 1, 0, 0);
        ex(c + 40, 1, 2, 5);
        btn_raw = 1'b1;
        at(c + 25);
        btn_raw = 1'b0;
        at(c + 42);

        // release glitch: two low cycles freeze repeat, the cadence shifts from c+22 to c+25
        c = cyc;
        pq[0].push_back(c + 6);
        pq[1].push_back(c + 6);
        pq[1].push_back(c + 16);
        pq[1].push_back(c + 19);
        pq[1].push_back(c + 25);
        pq[1].push_back(c + 28);
        pq[1].push_back(c + 31);
        ex(c + 20, 1, 1, 0); ex(c + 21, 1, 1, 1); ex(c + 22, 1, 1, 1); ex(c + 22, 1, 0, 1);
        ex(c + 23, 1, 1, 0); ex(c + 23, 1, 0, 1); ex(c + 35, 1, 0, 1); ex(c + 36, 1, 0, 0);
        ex(c + 36, 0, 0, 0); ex(c + 40, 0, 2, 2); ex(c + 40, 1, 2, 11);
        btn_raw = 1'b1;
        at(c + 18);
        btn_raw = 1'b0;
        at(c + 20);
        btn_raw = 1'b1;
        at(c + 30);
        btn_raw = 1'b0;
        at(c + 40);

        // reset mid-hold during a repeat pulse, then a full re-qualification with the button still high
        c = cyc;
        pq[0].push_back(c + 6);
        pq[1].push_back(c + 6);
        pq[1].push_back(c + 16);
        btn_raw = 1'b1;
        at(c + 16);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        r = cyc;
        pq[0].push_back(r + 6);
        pq[1].push_back(r + 6);
        ex(r + 5, 0, 0, 0);  ex(r + 5, 1, 1, 1);  ex(r + 6, 0, 0, 1);  ex(r + 6, 1, 0, 1);
        ex(r + 7, 0, 2, 1);  ex(r + 7, 1, 2, 1);
        at(r + 8);
        btn_raw = 1'b0;
        at(r + 16);

        // 17 clean presses wrap the downstream 4-bit counter to 1
        do_reset();
        for (int k = 0; k < 17; k++) begin
            c = cyc;
            pq[0].push_back(c + 6);
            pq[1].push_back(c + 6);
            btn_raw = 1'b1;
            at(c + 5);
            btn_raw = 1'b0;
            at(c + 12);
        end
        t = cyc + 1;
        ex(t, 0, 2, 1);
        ex(t, 1, 2, 1);
        at(t + 2);
        done = 1'b1;
    end

endmodule
